// File: rtl/button_step_ctrl.sv
// -----------------------------------------------------------------------------
// button_step_ctrl
//   Front-end for the 8-bit up/down counter. Two raw push-buttons are
//   synchronised and debounced. A press/repeat FSM then turns them into
//   single-cycle step pulses on `enable`, with the direction on `up`.
//
//   Optional feature macro: BTN_AUTO_REPEAT_EN
//     defined   : a held button repeats after REPEAT_DELAY cycles, then every
//                 REPEAT_PERIOD cycles (states DELAY / REPEAT).
//     undefined : exactly one pulse per press (state HELD). No repeat timer
//                 is built.
//
//   Ports
//     clk        in   system clock, rising edge
//     clr        in   asynchronous active-high reset
//     btn_up_raw in   raw increment button, active-high, asynchronous
//     btn_dn_raw in   raw decrement button, active-high, asynchronous
//     enable     out  one-cycle step pulse
//     up         out  step direction (1 = increment); holds between pulses
//     locked     out  high while both buttons are held (LOCKOUT)
// -----------------------------------------------------------------------------

// Per-button 2-flop synchroniser plus debounce counter.
module button_step_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TMR_W           = 24
) (
  input  logic clk,
  input  logic clr,
  input  logic raw_i,
  output logic level_o
);
  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised level disagrees with the
  // accepted level. The level flips on the D-th disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == TMR_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
endmodule

module button_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8,
  parameter int TMR_W           = 24
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  output logic enable,
  output logic up,
  output logic locked
);
  localparam int NUM_BTN = 2;
  localparam int MAX_TMR = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                         ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                         : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
      $clog2(MAX_TMR + 1) > TMR_W) begin : g_param_err
    $error("button_step_ctrl: parameter out of range");
  end

  // Bit 0 = increment button, bit 1 = decrement button.
  logic [NUM_BTN-1:0] raw, db;
  assign raw = {btn_dn_raw, btn_up_raw};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_step_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .TMR_W          (TMR_W)
    ) u_db (
      .clk    (clk),
      .clr    (clr),
      .raw_i  (raw[g]),
      .level_o(db[g])
    );
  end

  logic db_up, db_dn;
  assign db_up = db[0];
  assign db_dn = db[1];

`ifdef BTN_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKOUT} state_t;
  localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`else
  typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_t;
`endif

  state_t state_q, state_d;
  logic   enable_q, enable_d;
  logic   up_q, up_d;

  // While a press is being serviced, up_q remembers which button owns it.
  logic active, other;
  assign active = up_q ? db_up : db_dn;
  assign other  = up_q ? db_dn : db_up;

  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    up_d     = up_q;
`ifdef BTN_AUTO_REPEAT_EN
    tmr_d    = tmr_q;
`endif
    case (state_q)
      IDLE: begin
        if (db_up && db_dn) begin
          state_d = LOCKOUT;
        end else if (db_up || db_dn) begin
          enable_d = 1'b1;
          up_d     = db_up;
`ifdef BTN_AUTO_REPEAT_EN
          tmr_d    = DELAY_LOAD;
          state_d  = DELAY;
`else
          state_d  = HELD;
`endif
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      DELAY, REPEAT: begin
        // Release wins over a repeat pulse due on the same edge.
        if (!active) begin
          state_d = IDLE;
        end else if (other) begin
          state_d = LOCKOUT;
        end else if (tmr_q == '0) begin
          enable_d = 1'b1;
          tmr_d    = PERIOD_LOAD;
          state_d  = REPEAT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`else
      HELD: begin
        if (!active) begin
          state_d = IDLE;
        end else if (other) begin
          state_d = LOCKOUT;
        end
      end
`endif
      LOCKOUT: begin
        if (!db_up && !db_dn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      up_q     <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      up_q     <= up_d;
`ifdef BTN_AUTO_REPEAT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  assign enable = enable_q;
  assign up     = up_q;
  assign locked = (state_q == LOCKOUT);
endmodule

// File: tb/tb_button_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_step_ctrl
//   Directed vectors for button_step_ctrl with D=4, REPEAT_DELAY=20,
//   REPEAT_PERIOD=8. Edge e of a row is the e-th rising edge after the row's
//   inputs start; inputs change on the falling edge before it and outputs are
//   sampled 1 time unit after it. Expected pulse edges follow from:
//   press sampled at edge k -> pulse visible after edge k+6, repeats at +20
//   then every +8, release sampled at edge k -> FSM sees it at edge k+6.
//   Expectations adapt to whether BTN_AUTO_REPEAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_button_step_ctrl;
  logic clk = 1'b0;
  logic clr, bu, bd;
  logic enable, up, locked;

  always #5 clk = ~clk;

  button_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .TMR_W          (24)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_up_raw(bu),
    .btn_dn_raw(bd),
    .enable    (enable),
    .up        (up),
    .locked    (locked)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic u, input logic d, input logic c,
                      output logic en, output logic upv, output logic lk);
    @(negedge clk);
    bu = u; bd = d; clr = c;
    @(posedge clk);
    #1;
    en = enable; upv = up; lk = locked;
  endtask

  task automatic cmp_pulses(input string nm, input int gn, input logic [7:0][7:0] ge,
                            input logic [7:0] gu, input int en, input logic [7:0][7:0] ee,
                            input logic eu);
    chk({nm, " pulse count"}, gn, en);
    for (int i = 0; i < en && i < gn && i < 8; i++) begin
      chk($sformatf("%s pulse%0d edge", nm, i), 32'(ge[i]), 32'(ee[i]));
      chk($sformatf("%s pulse%0d up", nm, i), 32'(gu[i]), 32'(eu));
    end
  endtask

  typedef struct {
    string           name;
    int              ulo, uhi;   // edges where btn_up_raw is high (-1: never)
    int              dlo, dhi;   // edges where btn_dn_raw is high
    int              ncyc;
    int              np;         // expected pulse count
    logic [7:0][7:0] pe;         // expected pulse edges, entry 0 first
    logic            pup;        // expected up during every pulse
    int              llo, lhi;   // edges where locked is expected high
    logic            upend;      // expected up at end of row
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    logic            en, upv, lk;
    int              gn, lk_bad, rep_n;
    logic [7:0][7:0] ge, ee;
    logic [7:0]      gu;

`ifdef BTN_AUTO_REPEAT_EN
    rep_n = 5;
`else
    rep_n = 1;
`endif
    vecs[0] = '{name:"short3",  ulo:0,  uhi:2,  dlo:-1, dhi:-1, ncyc:20, np:0,
                pe:64'd0, pup:1'b1, llo:-1, lhi:-1, upend:1'b1};
    vecs[1] = '{name:"exactD",  ulo:0,  uhi:3,  dlo:-1, dhi:-1, ncyc:25, np:1,
                pe:{56'd0, 8'd6}, pup:1'b1, llo:-1, lhi:-1, upend:1'b1};
    vecs[2] = '{name:"up12",    ulo:0,  uhi:11, dlo:-1, dhi:-1, ncyc:30, np:1,
                pe:{56'd0, 8'd6}, pup:1'b1, llo:-1, lhi:-1, upend:1'b1};
    vecs[3] = '{name:"dnhold",  ulo:-1, uhi:-1, dlo:0,  dhi:51, ncyc:70, np:rep_n,
                pe:{24'd0, 8'd50, 8'd42, 8'd34, 8'd26, 8'd6}, pup:1'b0,
                llo:-1, lhi:-1, upend:1'b0};
    vecs[4] = '{name:"lockout", ulo:0,  uhi:40, dlo:10, dhi:40, ncyc:60, np:1,
                pe:{56'd0, 8'd6}, pup:1'b1, llo:16, lhi:46, upend:1'b1};
    vecs[5] = '{name:"dn12",    ulo:-1, uhi:-1, dlo:0,  dhi:11, ncyc:30, np:1,
                pe:{56'd0, 8'd6}, pup:1'b0, llo:-1, lhi:-1, upend:1'b0};
    vecs[6] = '{name:"both",    ulo:0,  uhi:7,  dlo:0,  dhi:7,  ncyc:25, np:0,
                pe:64'd0, pup:1'b0, llo:6, lhi:13, upend:1'b0};

    // Reset state
    clr = 1'b1; bu = 1'b0; bd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset enable", 32'(enable), 32'd0);
    chk("reset up",     32'(up),     32'd1);
    chk("reset locked", 32'(locked), 32'd0);
    step(1'b0, 1'b0, 1'b0, en, upv, lk);

    // Table rows
    for (int r = 0; r < NV; r++) begin
      repeat (5) step(1'b0, 1'b0, 1'b0, en, upv, lk);
      gn = 0; ge = '0; gu = '0; lk_bad = -1; upv = 1'b0;
      for (int e = 0; e < vecs[r].ncyc; e++) begin
        step(e >= vecs[r].ulo && e <= vecs[r].uhi,
             e >= vecs[r].dlo && e <= vecs[r].dhi, 1'b0, en, upv, lk);
        if (en === 1'b1) begin
          if (gn < 8) begin
            ge[gn] = 8'(e);
            gu[gn] = upv;
          end
          gn++;
        end
        if (lk !== (e >= vecs[r].llo && e <= vecs[r].lhi) && lk_bad < 0) lk_bad = e;
      end
      cmp_pulses(vecs[r].name, gn, ge, gu, vecs[r].np, vecs[r].pe, vecs[r].pup);
      chk({vecs[r].name, " locked first bad edge"}, lk_bad, -1);
      chk({vecs[r].name, " final up"}, 32'(upv), 32'(vecs[r].upend));
    end

    // Asynchronous clear mid-cycle while locked with up=0
    lk = 1'b0;
    for (int i = 0; i < 20 && lk !== 1'b1; i++) step(1'b1, 1'b1, 1'b0, en, upv, lk);
    chk("clrA locked before clear", 32'(lk), 32'd1);
    chk("clrA up before clear", 32'(upv), 32'd0);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("clrA async enable", 32'(enable), 32'd0);
    chk("clrA async up",     32'(up),     32'd1);
    chk("clrA async locked", 32'(locked), 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b1, en, upv, lk);
    repeat (10) step(1'b0, 1'b0, 1'b0, en, upv, lk);

    // Clear during auto-repeat with the button held through it
    gn = 0; ge = '0; gu = '0;
    for (int e = 0; e < 77; e++) begin
      step(1'b1, 1'b0, (e == 35 || e == 36), en, upv, lk);
      if (en === 1'b1) begin
        if (gn < 8) begin
          ge[gn] = 8'(e);
          gu[gn] = upv;
        end
        gn++;
      end
      if (e == 34) begin
        #1;
        clr = 1'b1;
        #1;
        chk("clrB async enable", 32'(enable), 32'd0);
      end
    end
`ifdef BTN_AUTO_REPEAT_EN
    ee = {16'd0, 8'd71, 8'd63, 8'd43, 8'd34, 8'd26, 8'd6};
    cmp_pulses("clrB", gn, ge, gu, 6, ee, 1'b1);
`else
    ee = {48'd0, 8'd43, 8'd6};
    cmp_pulses("clrB", gn, ge, gu, 2, ee, 1'b1);
`endif
    repeat (10) step(1'b0, 1'b0, 1'b0, en, upv, lk);
    chk("end locked", 32'(lk), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
